// File: rtl/fio_dcache_loader_if.sv
// Bus bundle for the D-cache FIO loader: host command/data handshakes plus port-B pins.
// The slave side is the loader itself; the master side is the host plus the port-B memory.
interface fio_dcache_loader_if #(
    parameter int AW = 9
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_write;
    logic [AW-1:0]  cmd_base;
    logic [AW:0]    cmd_len;
    logic           wr_valid;
    logic           wr_ready;
    logic [255:0]   wr_data;
    logic           rd_valid;
    logic           rd_ready;
    logic [255:0]   rd_data;
    logic           abort;
    logic           busy;
    logic           done;
    logic           err;
    logic           FIO_MEMWRITE;
    logic [AW-1:0]  FIO_ADDR;
    logic [255:0]   FIO_WRITE_DATA;
    logic [255:0]   FIO_READ_DATA;

    modport master (
        output cmd_valid, cmd_write, cmd_base, cmd_len,
        output wr_valid, wr_data, rd_ready, abort,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
        input  FIO_MEMWRITE, FIO_ADDR, FIO_WRITE_DATA,
        output FIO_READ_DATA
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_base, cmd_len,
        input  wr_valid, wr_data, rd_ready, abort,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
        output FIO_MEMWRITE, FIO_ADDR, FIO_WRITE_DATA,
        input  FIO_READ_DATA
    );
endinterface

// File: rtl/fio_dcache_loader.sv
// Host-side sequencer for the D-cache FIO port (port B of the eight 32-bit lanes).
// One command becomes a burst of 256-bit line writes (preload) or line reads (dump).
// Range checking uses AW+2 bits so base+len can never wrap past the top line.
module fio_dcache_loader #(
    parameter int mem_size   = 256,
    parameter int shmem_size = 256
) (
    input  logic                clk,
    input  logic                resetb,
    fio_dcache_loader_if.slave  bus
);
    localparam int DEPTH = mem_size + shmem_size;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        WR,
        RD_ISSUE,
        RD_CAPT,
        RD_OUT,
        FIN
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [AW-1:0]  r_addr;
    logic [AW:0]    r_remaining;
    logic           r_dir;
    logic           r_err;
    logic           r_rdValid;
    logic [255:0]   r_rdData;

    logic           w_cmdFire;
    logic           w_wrFire;
    logic           w_rdFire;
    logic           w_last;
    logic           w_abort;
    logic           w_illegal;
    logic [AW+1:0]  w_end;

    assign w_cmdFire = bus.cmd_valid && (r_state == IDLE);
    assign w_wrFire  = (r_state == WR) && bus.wr_valid;
    assign w_rdFire  = (r_state == RD_OUT) && bus.rd_ready;
    assign w_last    = (r_remaining == (AW+1)'(1));
    assign w_abort   = bus.abort && (r_state != IDLE) && (r_state != FIN);
    assign w_end     = {2'b00, r_addr} + {1'b0, r_remaining};
    assign w_illegal = (r_remaining == '0) || (w_end > (AW+2)'(DEPTH));

    // State register; reset drops any burst in flight without a done pulse
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode and the combinational handshake/port-B outputs
    always_comb begin
        w_stateNext        = r_state;
        bus.cmd_ready      = (r_state == IDLE);
        bus.wr_ready       = (r_state == WR);
        bus.busy           = (r_state != IDLE);
        bus.done           = (r_state == FIN);
        bus.err            = (r_state == FIN) && r_err;
        bus.rd_valid       = r_rdValid;
        bus.rd_data        = r_rdData;
        bus.FIO_MEMWRITE   = w_wrFire;
        bus.FIO_ADDR       = r_addr;
        bus.FIO_WRITE_DATA = bus.wr_data;
        case (r_state)
            IDLE:     if (w_cmdFire) w_stateNext = CHK;
            CHK: begin
                if (w_illegal)  w_stateNext = FIN;
                else if (r_dir) w_stateNext = WR;
                else            w_stateNext = RD_ISSUE;
            end
            WR:       if (w_wrFire && w_last) w_stateNext = FIN;
            RD_ISSUE: w_stateNext = RD_CAPT;
            RD_CAPT:  w_stateNext = RD_OUT;
            RD_OUT:   if (w_rdFire) w_stateNext = w_last ? FIN : RD_ISSUE;
            FIN:      w_stateNext = IDLE;
            default:  w_stateNext = IDLE;
        endcase
        if (w_abort) begin
            w_stateNext = IDLE;
        end
    end

    // Address/count bookkeeping, reject flag and the registered dump line
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_dir       <= 1'b0;
            r_err       <= 1'b0;
            r_rdValid   <= 1'b0;
            r_rdData    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmdFire) begin
                        r_addr      <= bus.cmd_base;
                        r_remaining <= bus.cmd_len;
                        r_dir       <= bus.cmd_write;
                        r_err       <= 1'b0;
                    end
                end
                CHK: begin
                    r_err <= w_illegal;
                end
                WR: begin
                    if (w_wrFire) begin
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                RD_CAPT: begin
                    r_rdData  <= bus.FIO_READ_DATA;
                    r_rdValid <= 1'b1;
                end
                RD_OUT: begin
                    if (w_rdFire) begin
                        r_rdValid   <= 1'b0;
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_abort) begin
                r_rdValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fio_dcache_loader.sv
// Self-checking bench for fio_dcache_loader: a command table plus abort and reset sequences.
// Port B is modelled as a BRAM with one-cycle read latency; a shadow array holds expected contents.
module tb_fio_dcache_loader;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    typedef struct {
        logic        write;
        int          base;
        int          len;
        int          stall;
        logic [31:0] seed;
        logic        laneMix;
        logic        expErr;
    } cmdVec_t;

    typedef struct {
        int           addr;
        logic [255:0] data;
    } wrExp_t;

    logic clk = 1'b0;
    logic resetb;
    int   cyc = 0;
    int   numChecks = 0;
    int   numFails = 0;

    logic [255:0] memModel [DEPTH];
    logic [255:0] shadow [DEPTH];
    wrExp_t       wrQ [$];
    logic [255:0] rdQ [$];
    cmdVec_t      vecs [11];

    fio_dcache_loader_if #(.AW(AW)) bus ();

    fio_dcache_loader #(
        .mem_size   (256),
        .shmem_size (256)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Free-running cycle count, read only at negedges
    always @(posedge clk) cyc <= cyc + 1;

    // Port-B BRAM model: write on enable, read data one cycle after the address
    always @(posedge clk) begin
        if (bus.FIO_MEMWRITE) memModel[bus.FIO_ADDR] <= bus.FIO_WRITE_DATA;
        bus.FIO_READ_DATA <= memModel[bus.FIO_ADDR];
    end

    function automatic logic [255:0] pattern(input logic [31:0] seed, input int k, input logic laneMix);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) begin
            d[32*i +: 32] = (seed + 32'(k)) ^ (laneMix ? (32'(i) << 24) : 32'h0);
        end
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Offer one command; call at posedge+1, returns at posedge+1 after the handshake edge
    task automatic issueCmd(input logic write, input int base, input int len, output int acc);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = write;
        bus.cmd_base  = AW'(base);
        bus.cmd_len   = (AW+1)'(len);
        @(negedge clk);
        checkOutput("cmd_ready at offer", bus.cmd_ready, 1);
        acc = cyc;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Run one table entry to completion, scoreboarding writes, dump lines, latency and done/err
    task automatic applyStimulus(input cmdVec_t v);
        int acc, k, stallCnt, firstAct, lastAct, doneCyc, guard, limit;
        logic doneSeen;
        wrExp_t w;
        issueCmd(v.write, v.base, v.len, acc);
        if (!v.expErr) begin
            for (int j = 0; j < v.len; j++) begin
                if (v.write) begin
                    w.addr = v.base + j;
                    w.data = pattern(v.seed, j, v.laneMix);
                    wrQ.push_back(w);
                    shadow[v.base + j] = w.data;
                end else begin
                    rdQ.push_back(shadow[v.base + j]);
                end
            end
        end
        k = 0; stallCnt = 0; firstAct = -1; lastAct = -1; doneCyc = -1;
        doneSeen = 1'b0; guard = 0;
        limit = v.len * (v.stall + 4) + 20;
        while (!doneSeen && guard < limit) begin
            bus.wr_valid = v.write && (k < v.len);
            bus.wr_data  = pattern(v.seed, k, v.laneMix);
            bus.rd_ready = (stallCnt >= v.stall);
            @(negedge clk);
            if (bus.FIO_MEMWRITE) begin
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected FIO_MEMWRITE", 1, 0);
                end else begin
                    w = wrQ.pop_front();
                    checkOutput("FIO_ADDR", 256'(bus.FIO_ADDR), 256'(w.addr));
                    checkOutput("FIO_WRITE_DATA", bus.FIO_WRITE_DATA, w.data);
                end
                if (firstAct < 0) firstAct = cyc;
                lastAct = cyc;
            end
            if (bus.wr_valid && bus.wr_ready) k++;
            if (bus.rd_valid) begin
                if (rdQ.size() == 0) begin
                    checkOutput("unexpected rd_valid", 1, 0);
                end else begin
                    checkOutput("rd_data", bus.rd_data, rdQ[0]);
                end
                if (firstAct < 0) firstAct = cyc;
                if (bus.rd_ready) begin
                    if (rdQ.size() != 0) void'(rdQ.pop_front());
                    lastAct = cyc;
                    stallCnt = 0;
                end else begin
                    stallCnt++;
                end
            end
            if (bus.done) begin
                doneSeen = 1'b1;
                doneCyc  = cyc;
                checkOutput("err with done", 256'(bus.err), 256'(v.expErr));
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        checkOutput("done seen within budget", 256'(doneSeen), 1);
        checkOutput("write queue drained", 256'(wrQ.size()), 0);
        checkOutput("read queue drained", 256'(rdQ.size()), 0);
        wrQ.delete();
        rdQ.delete();
        if (v.expErr) begin
            checkOutput("reject done latency", 256'(doneCyc - acc), 2);
        end else if (v.write) begin
            checkOutput("first write latency", 256'(firstAct - acc), 2);
            checkOutput("back-to-back writes", 256'(lastAct - firstAct), 256'(v.len - 1));
            checkOutput("done after last write", 256'(doneCyc - lastAct), 1);
        end else begin
            checkOutput("first rd_valid latency", 256'(firstAct - acc), 4);
            checkOutput("done after last read", 256'(doneCyc - lastAct), 1);
        end
        @(negedge clk);
        checkOutput("done single pulse", 256'(bus.done), 0);
        checkOutput("idle after command", 256'(bus.busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, guard, doneCnt;
        logic got;

        // write, base, len, stall, seed, laneMix, expErr
        vecs[0]  = '{1'b1, 'h10, 4,   0, 32'hA0,   1'b0, 1'b0};
        vecs[1]  = '{1'b0, 'h10, 4,   5, 32'h0,    1'b0, 1'b0};
        vecs[2]  = '{1'b1, 500,  13,  0, 32'h0,    1'b0, 1'b1};
        vecs[3]  = '{1'b1, 'h20, 0,   0, 32'h0,    1'b0, 1'b1};
        vecs[4]  = '{1'b0, 0,    0,   0, 32'h0,    1'b0, 1'b1};
        vecs[5]  = '{1'b0, 505,  8,   0, 32'h0,    1'b0, 1'b1};
        vecs[6]  = '{1'b1, 499,  13,  0, 32'h1000, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 499,  13,  1, 32'h0,    1'b0, 1'b0};
        vecs[8]  = '{1'b1, 0,    512, 0, 32'h5000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 0,    512, 0, 32'h0,    1'b0, 1'b0};
        vecs[10] = '{1'b0, 'h10, 2,   2, 32'h0,    1'b0, 1'b0};

        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        resetb        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
        bus.abort     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset cmd_ready", 256'(bus.cmd_ready), 1);
        checkOutput("reset busy", 256'(bus.busy), 0);
        checkOutput("reset rd_valid", 256'(bus.rd_valid), 0);
        checkOutput("reset rd_data", bus.rd_data, 0);
        checkOutput("reset done", 256'(bus.done), 0);
        checkOutput("reset err", 256'(bus.err), 0);
        checkOutput("reset FIO_MEMWRITE", 256'(bus.FIO_MEMWRITE), 0);
        checkOutput("reset FIO_ADDR", 256'(bus.FIO_ADDR), 0);
        @(posedge clk); #1;
        resetb = 1'b1;

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // Abort while the second line of an 8-line dump is waiting
        issueCmd(1'b0, 'h40, 8, acc);
        bus.rd_ready = 1'b1;
        got = 1'b0; guard = 0;
        while (!got && guard < 20) begin
            @(negedge clk);
            if (bus.rd_valid) begin
                checkOutput("abort test line 0", bus.rd_data, shadow['h40]);
                got = 1'b1;
            end
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("abort test line 0 seen", 256'(got), 1);
        bus.rd_ready = 1'b0;
        got = 1'b0; guard = 0;
        while (!got && guard < 20) begin
            @(negedge clk);
            if (bus.rd_valid) begin
                checkOutput("abort test line 1", bus.rd_data, shadow['h41]);
                got = 1'b1;
                bus.abort = 1'b1;
            end else begin
                @(posedge clk); #1;
                guard++;
            end
        end
        checkOutput("abort test line 1 seen", 256'(got), 1);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", 256'(bus.busy), 0);
        checkOutput("abort rd_valid", 256'(bus.rd_valid), 0);
        checkOutput("abort cmd_ready", 256'(bus.cmd_ready), 1);
        doneCnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done || bus.err) doneCnt++;
            @(negedge clk);
        end
        checkOutput("abort no done", 256'(doneCnt), 0);
        @(posedge clk); #1;

        // Reset asserted in the middle of a preload burst
        issueCmd(1'b1, 'h80, 8, acc);
        bus.wr_valid = 1'b1;
        bus.wr_data  = pattern(32'h7700, 0, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset test writing", 256'(bus.FIO_MEMWRITE), 1);
        @(posedge clk); #1;
        resetb = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("mid-WR reset cmd_ready", 256'(bus.cmd_ready), 1);
        checkOutput("mid-WR reset busy", 256'(bus.busy), 0);
        checkOutput("mid-WR reset wr_ready", 256'(bus.wr_ready), 0);
        checkOutput("mid-WR reset rd_valid", 256'(bus.rd_valid), 0);
        checkOutput("mid-WR reset rd_data", bus.rd_data, 0);
        checkOutput("mid-WR reset done", 256'(bus.done), 0);
        checkOutput("mid-WR reset err", 256'(bus.err), 0);
        checkOutput("mid-WR reset FIO_MEMWRITE", 256'(bus.FIO_MEMWRITE), 0);
        checkOutput("mid-WR reset FIO_ADDR", 256'(bus.FIO_ADDR), 0);
        @(posedge clk); #1;
        resetb = 1'b1;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        checkOutput("after reset no done", 256'(bus.done), 0);
        @(posedge clk); #1;

        applyStimulus(vecs[10]);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
